// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM states and the
// latched instruction fields.
package alu_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] OP_MOV = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT = 3'b110;
  localparam logic [OP_W-1:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [SIZE-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [SIZE-1:0]   rdata1_c,
  output logic [SIZE-1:0]   rdata2_c
);

  logic [SIZE-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_c = mem_q[raddr1_i];
  assign rdata2_c = mem_q[raddr2_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: accepts one instruction, reads operands, drives the
// external ALU, captures its result and writes it back to the register file.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      opcode,
  input  logic [1:0]      rd,
  input  logic [1:0]      rs1,
  input  logic [1:0]      rs2,
  input  logic [SIZE-1:0] imm,
  output logic [2:0]      alu_op,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  input  logic [SIZE-1:0] alu_y,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            zero
);

  state_e          state_q, state_d;
  instr_t          instr_q, instr_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [SIZE-1:0] alu_a_q, alu_a_d;
  logic [SIZE-1:0] alu_b_q, alu_b_d;
  logic [SIZE-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic            rf_we_c;
  logic [SIZE-1:0] rf_rdata1_c;
  logic [SIZE-1:0] rf_rdata2_c;

  alu_regfile #(.SIZE(SIZE)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we_c),
    .waddr_i  (instr_q.rd),
    .wdata_i  (result_q),
    .raddr1_i (instr_q.rs1),
    .raddr2_i (instr_q.rs2),
    .rdata1_c (rf_rdata1_c),
    .rdata2_c (rf_rdata2_c)
  );

  // Write-back happens at the edge that ends the WB cycle.
  assign rf_we_c = (state_q == ST_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2};
          if (opcode == OP_LDI) begin
            // LDI bypasses the ALU: result is ready for the WB cycle.
            result_d = imm;
            zero_d   = (imm == '0);
            state_d  = ST_WB;
          end else begin
            state_d  = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        alu_a_d  = rf_rdata1_c;
        alu_b_d  = rf_rdata2_c;
        alu_op_d = instr_q.opcode;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_y;
        zero_d   = (alu_y == '0);
        state_d  = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_WB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q  <= '0;
      alu_op_q <= OP_MOV;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      instr_q  <= instr_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign result      = result_q;
  assign zero        = zero_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences the 8-bit ALU datapath: it accepts one instruction at a time over a valid/ready handshake, reads operands from an internal 4-entry register file, drives the ALU operand and opcode lines, captures the ALU result and writes it back. It sits between the instruction source (testbench or future fetch unit) and the combinational ALU, which contains the add/sub/logic/mov units.

## Interface
Parameters:
- SIZE, 8, datapath width (register, operand and result width)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- instr_valid  in  1  instruction present on opcode/rd/rs1/rs2/imm
- instr_ready  out  1  sequencer can accept an instruction this cycle
- opcode  in  3  operation (see Operation)
- rd  in  2  destination register index
- rs1  in  2  first source register index
- rs2  in  2  second source register index
- imm  in  SIZE  immediate value (LDI only)
- alu_op  out  3  opcode presented to the ALU
- alu_a  out  SIZE  ALU operand A (registered)
- alu_b  out  SIZE  ALU operand B (registered)
- alu_y  in  SIZE  ALU result (combinational from alu_a/alu_b/alu_op)
- done  out  1  one-cycle pulse: write-back performed this cycle
- result  out  SIZE  value written back; held until next done
- zero  out  1  result == 0, updated with done

## Operation
- Opcodes: 000 MOV (rd=rs1), 001 ADD, 010 SUB (rs1-rs2), 011 AND, 100 OR, 101 XOR, 110 NOT (~rs1), 111 LDI (rd=imm, ALU bypassed).
- Arithmetic modulo 2^SIZE; carry/borrow discarded.
- FSM states: IDLE, FETCH, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid && instr_ready, latch opcode/rd/rs1/rs2/imm; go FETCH (LDI: go WB).
  - FETCH: alu_a<=R[rs1], alu_b<=R[rs2], alu_op<=latched opcode; go EXEC.
  - EXEC: sample alu_y into result register; go WB.
  - WB: R[rd]<=result (LDI: result<=imm and R[rd]<=imm); done=1; zero updated; go IDLE.
- instr_ready is low in FETCH, EXEC and WB; instr_valid is ignored there. Inputs need only be stable in the accept cycle.
- rd may equal rs1/rs2: operands are read in FETCH, before WB, so the old value is used.
- alu_a/alu_b/alu_op hold their last values outside FETCH.

## Timing
- Accept at edge 0 (ALU op): FETCH cycle 1, EXEC cycle 2, WB/done cycle 3; instr_ready high again cycle 4. Throughput 1 instruction per 4 cycles.
- LDI: accept edge 0, WB/done cycle 1, ready cycle 2.
- Register written at the rising edge ending the WB cycle. A following instruction accepted at cycle 4 reads the new value.
- Reset (rst_n low at a rising edge): state IDLE; R0..R3=0; alu_a=alu_b=0; alu_op=000; result=0; zero=1; done=0; instr_ready=1 from the first cycle after reset.
- Reset mid-operation (FETCH/EXEC/WB): instruction aborted, no write-back, no done pulse.

## Structure
- Shared package alu_pkg: opcode constants (OP_MOV..OP_LDI), state encoding localparams (2-bit), register count (4).
- Sub-module alu_regfile: 4 x SIZE, two combinational read ports, one synchronous write port with write enable, synchronous active-low clear.
- The ALU itself is external; the bench supplies a reference ALU on alu_y.

## Test plan
- Reset: after rst_n low then high: result=0, zero=1, done=0, instr_ready=1; MOV R1,R0 gives result 0x00.
- LDI R0,0x2A; LDI R1,0x16: done at accept+1 each; ADD R2,R0,R1: done at accept+3, result=0x40, zero=0.
- SUB R3,R1,R0 (0x16-0x2A): result=0xEC. XOR R0,R0,R0: result=0x00, zero=1.
- Wrap and aliasing: LDI R1,0xFF; ADD R1,R1,R1: result=0xFE; R1 reads 0xFE afterward.
- Handshake: hold instr_valid high with changing fields during FETCH/EXEC/WB: only the first instruction executes; instr_ready=0 for exactly 3 cycles.
- Reset in EXEC of ADD R2 (R2 previously 0x40): no done pulse; R2=0; instr_ready=1 one cycle after reset.
